// File: rtl/ofs_reset_sequencer.sv
// ofs_reset_sequencer: brings FIM subsystems out of reset one at a time
// (PCIe SS, EMIF, HSSI, PMCI, AFU) once the system PLL is locked and PCIe
// reset is released. Each stage must report done before the next one is
// released; a stage that never reports done parks the block in ERROR.
`timescale 1ns/1ps
module ofs_reset_sequencer #(
    parameter int NUM_STAGES    = 5,
    parameter int HOLD_CYCLES   = 16,
    parameter int SETTLE_CYCLES = 8,
    parameter int STAGE_TIMEOUT = 4096,
    localparam int STAGE_W      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pll_locked,
    input  logic                  pcie_rst_n,
    input  logic [NUM_STAGES-1:0] stage_en,
    input  logic [NUM_STAGES-1:0] stage_done,
    input  logic                  soft_reset_req,
    output logic [NUM_STAGES-1:0] stage_rst_n,
    output logic                  seq_done,
    output logic                  seq_error,
    output logic [STAGE_W-1:0]    err_stage,
    output logic [STAGE_W-1:0]    cur_stage
);

    localparam int LOCK_W = $clog2(HOLD_CYCLES) + 1;
    localparam int TMO_W  = $clog2(STAGE_TIMEOUT) + 1;
    localparam int SET_W  = $clog2(SETTLE_CYCLES) + 1;

    localparam logic [LOCK_W-1:0]  LOCK_LAST  = LOCK_W'(HOLD_CYCLES - 1);
    localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(STAGE_TIMEOUT - 1);
    // The WAIT_DONE cycle that sees done and the RELEASE cycle both count
    // as idle time, so SETTLE itself only has to cover the remainder.
    localparam logic [SET_W-1:0]   SET_LAST   = (SETTLE_CYCLES > 2) ? SET_W'(SETTLE_CYCLES - 2) : {SET_W{1'b0}};
    localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(NUM_STAGES - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_RELEASE   = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_SETTLE    = 3'd4,
        ST_DONE      = 3'd5,
        ST_ERROR     = 3'd6
    } state_t;

    // synchronizer chains and previous-value flops for edge detection
    logic [1:0]            lock_sync_r;
    logic [1:0]            pcie_sync_r;
    logic [NUM_STAGES-1:0] done_meta_r;
    logic [NUM_STAGES-1:0] done_sync_r;
    logic                  lock_prev_r;
    logic                  pcie_prev_r;
    logic                  lock_s;
    logic                  pcie_s;
    logic                  restart_s;

    // sequencer state and its next-state values
    state_t                state_r,       state_s;
    logic [STAGE_W-1:0]    k_r,           k_s;
    logic [LOCK_W-1:0]     lock_cnt_r,    lock_cnt_s;
    logic [TMO_W-1:0]      tmo_cnt_r,     tmo_cnt_s;
    logic [SET_W-1:0]      settle_cnt_r,  settle_cnt_s;
    logic [NUM_STAGES-1:0] stage_rst_n_r, stage_rst_n_s;
    logic                  seq_done_r,    seq_done_s;
    logic                  seq_error_r,   seq_error_s;
    logic [STAGE_W-1:0]    err_stage_r,   err_stage_s;
    logic [STAGE_W-1:0]    cur_stage_r,   cur_stage_s;

    assign lock_s = lock_sync_r[1];
    assign pcie_s = pcie_sync_r[1];

    // A falling lock / PCIe reset or a soft request restarts from scratch.
    assign restart_s = (state_r != ST_IDLE) &&
                       (soft_reset_req ||
                        (lock_prev_r && !lock_s) ||
                        (pcie_prev_r && !pcie_s));

    assign stage_rst_n = stage_rst_n_r;
    assign seq_done    = seq_done_r;
    assign seq_error   = seq_error_r;
    assign err_stage   = err_stage_r;
    assign cur_stage   = cur_stage_r;

    // Two-flop synchronizers for the asynchronous inputs plus edge history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_sync_r <= 2'b00;
            pcie_sync_r <= 2'b00;
            done_meta_r <= '0;
            done_sync_r <= '0;
            lock_prev_r <= 1'b0;
            pcie_prev_r <= 1'b0;
        end else begin
            lock_sync_r <= {lock_sync_r[0], pll_locked};
            pcie_sync_r <= {pcie_sync_r[0], pcie_rst_n};
            done_meta_r <= stage_done;
            done_sync_r <= done_meta_r;
            lock_prev_r <= lock_s;
            pcie_prev_r <= pcie_s;
        end
    end

    // Next-state, counter and output-register values for the sequencer.
    always_comb begin
        state_s       = state_r;
        k_s           = k_r;
        lock_cnt_s    = lock_cnt_r;
        tmo_cnt_s     = tmo_cnt_r;
        settle_cnt_s  = settle_cnt_r;
        stage_rst_n_s = stage_rst_n_r;
        seq_done_s    = seq_done_r;
        seq_error_s   = seq_error_r;
        err_stage_s   = err_stage_r;

        if (restart_s) begin
            state_s       = ST_WAIT_LOCK;
            k_s           = '0;
            lock_cnt_s    = '0;
            tmo_cnt_s     = '0;
            settle_cnt_s  = '0;
            stage_rst_n_s = '0;
            seq_done_s    = 1'b0;
            seq_error_s   = 1'b0;
            err_stage_s   = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (lock_s && pcie_s) begin
                        if (lock_cnt_r == LOCK_LAST) begin
                            state_s    = ST_RELEASE;
                            k_s        = '0;
                            lock_cnt_s = '0;
                        end else begin
                            lock_cnt_s = lock_cnt_r + 1'b1;
                        end
                    end else begin
                        lock_cnt_s = '0;
                    end
                end
                ST_RELEASE: begin
                    if (stage_en[k_r]) begin
                        stage_rst_n_s[k_r] = 1'b1;
                        tmo_cnt_s          = '0;
                        state_s            = ST_WAIT_DONE;
                    end else if (k_r == STAGE_LAST) begin
                        state_s = ST_DONE;
                    end else begin
                        k_s = k_r + 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (done_sync_r[k_r]) begin
                        settle_cnt_s = '0;
                        state_s      = ST_SETTLE;
                    end else if (tmo_cnt_r == TMO_LAST) begin
                        state_s = ST_ERROR;
                    end else begin
                        tmo_cnt_s = tmo_cnt_r + 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt_r >= SET_LAST) begin
                        if (k_r == STAGE_LAST) begin
                            state_s = ST_DONE;
                        end else begin
                            k_s     = k_r + 1'b1;
                            state_s = ST_RELEASE;
                        end
                    end else begin
                        settle_cnt_s = settle_cnt_r + 1'b1;
                    end
                end
                ST_DONE: begin
                    seq_done_s = 1'b1;
                end
                ST_ERROR: begin
                    seq_error_s        = 1'b1;
                    err_stage_s        = k_r;
                    stage_rst_n_s[k_r] = 1'b0;
                end
                default: begin
                    state_s       = ST_IDLE;
                    k_s           = '0;
                    stage_rst_n_s = '0;
                    seq_done_s    = 1'b0;
                    seq_error_s   = 1'b0;
                    err_stage_s   = '0;
                end
            endcase
        end
    end

    // Debug stage index: follows k while a stage is active, holds at the end.
    always_comb begin
        cur_stage_s = '0;
        case (state_s)
            ST_RELEASE, ST_WAIT_DONE, ST_SETTLE: cur_stage_s = k_s;
            ST_DONE, ST_ERROR:                   cur_stage_s = cur_stage_r;
            default:                             cur_stage_s = '0;
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            k_r           <= '0;
            lock_cnt_r    <= '0;
            tmo_cnt_r     <= '0;
            settle_cnt_r  <= '0;
            stage_rst_n_r <= '0;
            seq_done_r    <= 1'b0;
            seq_error_r   <= 1'b0;
            err_stage_r   <= '0;
            cur_stage_r   <= '0;
        end else begin
            state_r       <= state_s;
            k_r           <= k_s;
            lock_cnt_r    <= lock_cnt_s;
            tmo_cnt_r     <= tmo_cnt_s;
            settle_cnt_r  <= settle_cnt_s;
            stage_rst_n_r <= stage_rst_n_s;
            seq_done_r    <= seq_done_s;
            seq_error_r   <= seq_error_s;
            err_stage_r   <= err_stage_s;
            cur_stage_r   <= cur_stage_s;
        end
    end

endmodule

// File: tb/tb_ofs_reset_sequencer.sv
// Bench for ofs_reset_sequencer: table-driven and random bring-up scenarios
// checked every cycle against a timeline model, plus directed sequences for
// lock glitch, timeout, soft-reset recovery, PCIe drop and async reset.
`timescale 1ns/1ps
module tb_ofs_reset_sequencer;

    localparam int NS     = 5;
    localparam int HOLD   = 16;
    localparam int SETTLE = 8;
    localparam int TMO    = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pll_locked;
    logic          pcie_rst_n;
    logic [NS-1:0] stage_en;
    logic [NS-1:0] stage_done;
    logic          soft_reset_req;
    logic [NS-1:0] stage_rst_n;
    logic          seq_done;
    logic          seq_error;
    logic [2:0]    err_stage;
    logic [2:0]    cur_stage;
    logic [9:0]    obs;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // timeline model: cycle numbers at which each event becomes visible
    int rel_t [NS];
    int dp_t  [NS];
    int done_t, err_t, err_k, end_t;

    typedef struct {
        logic [NS-1:0]      en;
        logic [NS-1:0][7:0] dly;
        logic [NS-1:0]      exp_rst;
        logic               exp_done;
        logic               exp_err;
        logic [2:0]         exp_es;
    } vec_t;

    vec_t tbl [8];

    assign obs = {stage_rst_n, seq_done, seq_error, err_stage};

    always #5 clk = ~clk;

    ofs_reset_sequencer #(
        .NUM_STAGES    (NS),
        .HOLD_CYCLES   (HOLD),
        .SETTLE_CYCLES (SETTLE),
        .STAGE_TIMEOUT (TMO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pll_locked     (pll_locked),
        .pcie_rst_n     (pcie_rst_n),
        .stage_en       (stage_en),
        .stage_done     (stage_done),
        .soft_reset_req (soft_reset_req),
        .stage_rst_n    (stage_rst_n),
        .seq_done       (seq_done),
        .seq_error      (seq_error),
        .err_stage      (err_stage),
        .cur_stage      (cur_stage)
    );

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, act, exp);
        end
    endtask

    task automatic run_to(input int t);
        while (cyc < t) step();
    endtask

    task automatic set_vec(input int i, input logic [NS-1:0] en, input logic [NS-1:0][7:0] dly,
                           input logic [NS-1:0] r, input logic d, input logic e, input logic [2:0] es);
        tbl[i].en = en; tbl[i].dly = dly; tbl[i].exp_rst = r;
        tbl[i].exp_done = d; tbl[i].exp_err = e; tbl[i].exp_es = es;
    endtask

    // Build the expected event timeline from the sequencing rules: the first
    // action comes HOLD+3 after lock, each later one SETTLE+3 after the
    // previous done pin, every skipped stage adds one cycle, and a stage whose
    // synchronized done arrives past the last timeout count errors out.
    task automatic plan(input logic [NS-1:0] en, input logic [NS-1:0][7:0] dly, input int l0);
        int t;
        t = l0 + HOLD + 3;
        done_t = -1; err_t = -1; err_k = 0;
        for (int k = 0; k < NS; k++) begin
            rel_t[k] = -1;
            dp_t[k]  = -1;
        end
        for (int k = 0; k < NS; k++) begin
            if (err_t < 0) begin
                if (!en[k]) begin
                    t = t + 1;
                end else begin
                    rel_t[k] = t;
                    dp_t[k]  = t + int'(dly[k]);
                    if (int'(dly[k]) + 2 > TMO - 1) begin
                        err_t = t + TMO + 1;
                        err_k = k;
                    end else begin
                        t = dp_t[k] + SETTLE + 3;
                    end
                end
            end
        end
        if (err_t < 0) done_t = t;
        end_t = ((err_t >= 0) ? err_t : done_t) + 6;
    endtask

    function automatic logic [9:0] expect_at(input int c);
        logic [NS-1:0] r;
        logic          e;
        r = '0;
        for (int k = 0; k < NS; k++)
            if (rel_t[k] >= 0 && c >= rel_t[k]) r[k] = 1'b1;
        e = (err_t >= 0 && c >= err_t);
        if (e) r[err_k] = 1'b0;
        return {r, (done_t >= 0 && c >= done_t), e, e ? 3'(err_k) : 3'd0};
    endfunction

    // done pins per the model; disabled stages and finished sequences see noise
    task automatic drive_done(input int c);
        logic [NS-1:0] d;
        for (int k = 0; k < NS; k++)
            d[k] = stage_en[k] ? (dp_t[k] >= 0 && c >= dp_t[k]) : 1'($urandom_range(0, 1));
        if ((done_t >= 0 && c >= done_t) || (err_t >= 0 && c >= err_t))
            d = NS'($urandom);
        stage_done = d;
    endtask

    task automatic do_reset(input logic [NS-1:0] en);
        rst_n = 1'b0; pll_locked = 1'b0; pcie_rst_n = 1'b1;
        stage_done = '0; soft_reset_req = 1'b0; stage_en = en;
        step();
        step();
        check("reset_outputs", 32'(obs), 32'(0));
        check("reset_cur_stage", 32'(cur_stage), 32'(0));
        rst_n = 1'b1;
        repeat (4) step();
    endtask

    task automatic run_scenario(input logic [NS-1:0] en, input logic [NS-1:0][7:0] dly);
        do_reset(en);
        pll_locked = 1'b1;
        plan(en, dly, cyc);
        drive_done(cyc);
        while (cyc < end_t) begin
            step();
            check("model", 32'(obs), 32'(expect_at(cyc)));
            for (int k = 0; k < NS; k++)
                if (rel_t[k] == cyc) check("cur_stage", 32'(cur_stage), 32'(k));
            drive_done(cyc);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int l0, l1, w;
        logic [NS-1:0]      ren;
        logic [NS-1:0][7:0] rdly;

        set_vec(0, 5'b11111, {8'd20, 8'd20, 8'd20, 8'd20, 8'd20}, 5'b11111, 1'b1, 1'b0, 3'd0);
        set_vec(1, 5'b11011, {8'd20, 8'd20, 8'd20, 8'd20, 8'd20}, 5'b11011, 1'b1, 1'b0, 3'd0);
        set_vec(2, 5'b11111, {8'd20, 8'd20, 8'd20, 8'd255, 8'd20}, 5'b00001, 1'b0, 1'b1, 3'd1);
        set_vec(3, 5'b00000, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0},       5'b00000, 1'b1, 1'b0, 3'd0);
        set_vec(4, 5'b11111, {8'd0, 8'd0, 8'd61, 8'd0, 8'd0},      5'b11111, 1'b1, 1'b0, 3'd0);
        set_vec(5, 5'b11111, {8'd0, 8'd0, 8'd62, 8'd0, 8'd0},      5'b00011, 1'b0, 1'b1, 3'd2);
        set_vec(6, 5'b10101, {8'd255, 8'd5, 8'd5, 8'd5, 8'd5},     5'b00101, 1'b0, 1'b1, 3'd4);
        set_vec(7, 5'b01110, {8'd5, 8'd5, 8'd5, 8'd5, 8'd5},       5'b01110, 1'b1, 1'b0, 3'd0);

        for (int i = 0; i < 8; i++) begin
            run_scenario(tbl[i].en, tbl[i].dly);
            check("table_final", 32'(obs),
                  32'({tbl[i].exp_rst, tbl[i].exp_done, tbl[i].exp_err, tbl[i].exp_es}));
        end

        for (int r = 0; r < 6; r++) begin
            ren = NS'($urandom);
            for (int k = 0; k < NS; k++) rdly[k] = 8'($urandom_range(0, 61));
            if ($urandom_range(0, 2) == 0) rdly[$urandom_range(0, NS - 1)] = 8'd200;
            run_scenario(ren, rdly);
        end

        // lock glitch: high 10, low 1, high again -> hold count restarts
        do_reset(5'b11111);
        l0 = cyc;
        pll_locked = 1'b1;
        run_to(l0 + 10);
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        l1 = cyc;
        while (cyc < l1 + 18) begin
            step();
            if (cyc == l0 + 19) check("glitch_no_early_release", 32'(stage_rst_n), 32'(0));
        end
        check("glitch_pre_release", 32'(stage_rst_n), 32'(0));
        step();
        check("glitch_release", 32'(stage_rst_n), 32'(5'b00001));

        // timeout on stage 1, then soft-reset recovery
        do_reset(5'b11111);
        l0 = cyc;
        pll_locked = 1'b1;
        run_to(l0 + 19);
        check("to_stage0_release", 32'(stage_rst_n), 32'(5'b00001));
        run_to(l0 + 39);
        stage_done = 5'b00001;
        run_to(l0 + 49);
        check("to_stage1_pre", 32'(stage_rst_n), 32'(5'b00001));
        step();
        check("to_stage1_release", 32'(stage_rst_n), 32'(5'b00011));
        run_to(l0 + 50 + 64);
        check("to_no_early_error", 32'(seq_error), 32'(0));
        step();
        check("to_error", 32'({seq_error, err_stage}), 32'({1'b1, 3'd1}));
        check("to_error_rst", 32'(stage_rst_n), 32'(5'b00001));
        soft_reset_req = 1'b1;
        step();
        soft_reset_req = 1'b0;
        check("soft_reset_clear", 32'(obs), 32'(0));
        stage_done = 5'b11111;
        w = 0;
        while (!seq_done && w < 200) begin
            step();
            w++;
        end
        check("recover_done", 32'({seq_done, seq_error}), 32'(2'b10));
        check("recover_rst", 32'(stage_rst_n), 32'(5'b11111));

        // PCIe reset dropped in DONE: all resets three cycles later
        l0 = cyc;
        pcie_rst_n = 1'b0;
        run_to(l0 + 2);
        check("pcie_drop_pre", 32'({stage_rst_n, seq_done}), 32'(6'b111111));
        step();
        check("pcie_drop_rst", 32'({stage_rst_n, seq_done}), 32'(6'b000000));

        // asynchronous reset in the middle of WAIT_DONE
        do_reset(5'b11111);
        l0 = cyc;
        pll_locked = 1'b1;
        run_to(l0 + 24);
        check("async_pre", 32'(stage_rst_n), 32'(5'b00001));
        #3;
        rst_n = 1'b0;
        #1;
        check("async_outputs", 32'(obs), 32'(0));
        check("async_cur_stage", 32'(cur_stage), 32'(0));
        #1;
        rst_n = 1'b1;
        step();
        check("async_after_release", 32'(stage_rst_n), 32'(0));
        w = 0;
        while (stage_rst_n[0] !== 1'b1 && w < 40) begin
            step();
            w++;
        end
        check("async_resequence", 32'(stage_rst_n), 32'(5'b00001));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
